solid_box_scan: RTL

Sequential collision scanner that tests an axis-aligned box against the 1-bit solid map, one map cell per cycle. It supersedes the single-point `is_solid` lookup for player/object movement. Map size, coordinate width, box extent and out-of-bounds policy are parameters. It adds a first-hit/full-count mode and reports the first solid cell. It sits between the object physics FSMs (request side) and the solid-map RAM (read port side).

---
 rtl/solid_box_scan.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/solid_box_scan.sv
// solid_box_scan: tests an axis-aligned box against the 1-bit solid map,
// one map cell per cycle, row-major, with first-hit or full-count modes.
//
// Handshakes: a transfer happens on any rising clock edge where valid and
// ready are both high. The request side holds req_* stable while req_valid
// is high and req_ready is low; the scanner holds rsp_* stable while
// rsp_valid is high and rsp_ready is low. Neither valid depends on ready.
module solid_box_scan #(
    parameter int MAP_W     = 128,
    parameter int MAP_H     = 128,
    parameter int COORD_W   = 16,
    parameter int SIZE_W    = 5,
    parameter int OOB_SOLID = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic signed [COORD_W-1:0]      req_x,
    input  logic signed [COORD_W-1:0]      req_y,
    input  logic [SIZE_W-1:0]              req_w,
    input  logic [SIZE_W-1:0]              req_h,
    input  logic                           req_mode,
    output logic                           map_rd_en,
    output logic [$clog2(MAP_W*MAP_H)-1:0] map_rd_addr,
    input  logic                           map_rd_data,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic                           rsp_hit,
    output logic [2*SIZE_W-1:0]            rsp_count,
    output logic signed [COORD_W-1:0]      rsp_first_x,
    output logic signed [COORD_W-1:0]      rsp_first_y,
    output logic [1:0]                     dbg_state
);

    localparam int XW = $clog2(MAP_W);
    localparam int YW = $clog2(MAP_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Cell coordinates carry one extra bit so req_x + i never wraps.
    typedef logic signed [COORD_W:0] ext_t;

    state_t                     r_state, w_next;
    logic signed [COORD_W-1:0]  r_x, r_y;
    logic [SIZE_W-1:0]          r_w, r_h, r_i, r_j;
    logic                       r_mode;
    logic                       r_pend, r_force;
    logic signed [COORD_W-1:0]  r_px, r_py;
    logic [2*SIZE_W-1:0]        r_count;
    logic signed [COORD_W-1:0]  r_fx, r_fy;

    ext_t                       w_cx, w_cy;
    logic                       w_x_lo, w_x_hi, w_y_lo, w_y_hi, w_oob;
    logic [XW-1:0]              w_x_cl;
    logic [YW-1:0]              w_y_cl;
    logic                       w_solid, w_stop, w_last, w_issue, w_accept;

    // Current cell address: clamp each axis into the map independently.
    always_comb begin
        w_cx   = ext_t'(r_x) + ext_t'({1'b0, r_i});
        w_cy   = ext_t'(r_y) + ext_t'({1'b0, r_j});
        w_x_lo = w_cx[COORD_W];
        w_y_lo = w_cy[COORD_W];
        w_x_hi = !w_x_lo && (w_cx >= ext_t'(MAP_W));
        w_y_hi = !w_y_lo && (w_cy >= ext_t'(MAP_H));
        w_oob  = w_x_lo || w_x_hi || w_y_lo || w_y_hi;
        w_x_cl = w_x_lo ? '0 : (w_x_hi ? '1 : w_cx[XW-1:0]);
        w_y_cl = w_y_lo ? '0 : (w_y_hi ? '1 : w_cy[YW-1:0]);
    end

    // Returning result, early stop in first-hit mode, and issue qualification.
    always_comb begin
        w_solid     = r_pend && (r_force || map_rd_data);
        w_stop      = !r_mode && w_solid;
        w_last      = (r_i == r_w - 1'b1) && (r_j == r_h - 1'b1);
        w_issue     = (r_state == S_SCAN) && !w_stop && !rst;
        map_rd_en   = w_issue && !((OOB_SOLID != 0) && w_oob);
        map_rd_addr = {w_y_cl, w_x_cl};
        w_accept    = req_valid && req_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic and handshake outputs; everything is held low in reset.
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    w_next = (req_w == '0 || req_h == '0) ? S_RESP : S_SCAN;
            end
            S_SCAN: begin
                if (w_stop)      w_next = S_RESP;
                else if (w_last) w_next = S_DRAIN;
            end
            S_DRAIN: w_next = S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (rst) begin
            req_ready = 1'b0;
            rsp_valid = 1'b0;
        end
    end

    // Request latch, cell walk, 1-deep coordinate pipeline and result accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_mode  <= 1'b0;
            r_i     <= '0;
            r_j     <= '0;
            r_pend  <= 1'b0;
            r_force <= 1'b0;
            r_px    <= '0;
            r_py    <= '0;
            r_count <= '0;
            r_fx    <= '0;
            r_fy    <= '0;
        end else begin
            r_pend  <= w_issue;
            r_force <= w_issue && (OOB_SOLID != 0) && w_oob;
            r_px    <= w_cx[COORD_W-1:0];
            r_py    <= w_cy[COORD_W-1:0];
            if (w_accept) begin
                r_x     <= req_x;
                r_y     <= req_y;
                r_w     <= req_w;
                r_h     <= req_h;
                r_mode  <= req_mode;
                r_i     <= '0;
                r_j     <= '0;
                r_count <= '0;
                r_fx    <= '0;
                r_fy    <= '0;
            end else begin
                if (w_issue) begin
                    if (r_i == r_w - 1'b1) begin
                        r_i <= '0;
                        r_j <= r_j + 1'b1;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                if (w_solid) begin
                    r_count <= r_count + 1'b1;
                    if (r_count == '0) begin
                        r_fx <= r_px;
                        r_fy <= r_py;
                    end
                end
            end
        end
    end

    assign rsp_hit     = (r_count != '0);
    assign rsp_count   = r_count;
    assign rsp_first_x = r_fx;
    assign rsp_first_y = r_fy;
    assign dbg_state   = r_state;

endmodule
